// File: rtl/ycr_tapc_pkg.sv
// Shared TAP controller definitions: FSM state encoding and default IR opcodes.
// Also used by the DR decoder so opcode values stay in one place.
package ycr_tapc_pkg;

  localparam int YCR_TAP_STATE_WIDTH = 4;
  localparam int YCR_TAP_IR_WIDTH    = 5;

  localparam logic [YCR_TAP_IR_WIDTH-1:0] YCR_TAP_IR_IDCODE = 5'h01;
  localparam logic [YCR_TAP_IR_WIDTH-1:0] YCR_TAP_IR_BYPASS = 5'h1F;

  typedef enum logic [YCR_TAP_STATE_WIDTH-1:0] {
    TLR    = 4'h0,
    RTI    = 4'h1,
    SEL_DR = 4'h2,
    CAP_DR = 4'h3,
    SH_DR  = 4'h4,
    EX1_DR = 4'h5,
    PA_DR  = 4'h6,
    EX2_DR = 4'h7,
    UPD_DR = 4'h8,
    SEL_IR = 4'h9,
    CAP_IR = 4'hA,
    SH_IR  = 4'hB,
    EX1_IR = 4'hC,
    PA_IR  = 4'hD,
    EX2_IR = 4'hE,
    UPD_IR = 4'hF
  } type_ycr_tapc_state_e;

endpackage

// File: rtl/ycr_tapc_ir.sv
// TAP instruction register: capture/shift stage plus the update latch that
// drives ir_value. The update latch is reloaded with IDCODE while in Test-Logic-Reset.
module ycr_tapc_ir
  import ycr_tapc_pkg::*;
#(
  parameter int                    YCR_IR_WIDTH  = YCR_TAP_IR_WIDTH,
  parameter logic [YCR_IR_WIDTH-1:0] YCR_IR_IDCODE = YCR_IR_WIDTH'(1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tdi,
  input  logic                    tlr,
  input  logic                    capture,
  input  logic                    shift,
  input  logic                    update,
  output logic                    ir_lsb,
  output logic [YCR_IR_WIDTH-1:0] ir_value
);

  // The two LSBs of the capture pattern are fixed at 2'b01 by 1149.1.
  localparam logic [YCR_IR_WIDTH-1:0] IR_CAPTURE = YCR_IR_WIDTH'(1);

  logic [YCR_IR_WIDTH-1:0] ir_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_shift <= '0;
    end else if (capture) begin
      ir_shift <= IR_CAPTURE;
    end else if (shift) begin
      ir_shift <= {tdi, ir_shift[YCR_IR_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_value <= YCR_IR_IDCODE;
    end else if (tlr) begin
      ir_value <= YCR_IR_IDCODE;
    end else if (update) begin
      ir_value <= ir_shift;
    end
  end

  assign ir_lsb = ir_shift[0];

endmodule

// File: rtl/ycr_tapc_fsm.sv
// IEEE 1149.1 TAP controller: TMS-driven state machine, BYPASS register,
// per-DR strobes and the registered TDO mux. The IR lives in ycr_tapc_ir.
module ycr_tapc_fsm
  import ycr_tapc_pkg::*;
#(
  parameter int                      YCR_IR_WIDTH  = YCR_TAP_IR_WIDTH,
  parameter logic [YCR_IR_WIDTH-1:0] YCR_IR_IDCODE = YCR_IR_WIDTH'(1),
  parameter logic [YCR_IR_WIDTH-1:0] YCR_IR_BYPASS = {YCR_IR_WIDTH{1'b1}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tms,
  input  logic                    tdi,
  input  logic                    dr_tdo,
  input  logic                    dr_impl,
  output logic                    tdo,
  output logic                    tdo_en,
  output logic                    fsm_rst_n_sync,
  output logic                    fsm_dr_capture,
  output logic                    fsm_dr_shift,
  output logic                    fsm_dr_update,
  output logic [YCR_IR_WIDTH-1:0] ir_value
);

  type_ycr_tapc_state_e state;
  type_ycr_tapc_state_e state_next;

  logic ir_lsb;
  logic bypass_q;
  logic bypass_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= TLR;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      TLR:    state_next = tms ? TLR    : RTI;
      RTI:    state_next = tms ? SEL_DR : RTI;
      SEL_DR: state_next = tms ? SEL_IR : CAP_DR;
      CAP_DR: state_next = tms ? EX1_DR : SH_DR;
      SH_DR:  state_next = tms ? EX1_DR : SH_DR;
      EX1_DR: state_next = tms ? UPD_DR : PA_DR;
      PA_DR:  state_next = tms ? EX2_DR : PA_DR;
      EX2_DR: state_next = tms ? UPD_DR : SH_DR;
      UPD_DR: state_next = tms ? SEL_DR : RTI;
      SEL_IR: state_next = tms ? TLR    : CAP_IR;
      CAP_IR: state_next = tms ? EX1_IR : SH_IR;
      SH_IR:  state_next = tms ? EX1_IR : SH_IR;
      EX1_IR: state_next = tms ? UPD_IR : PA_IR;
      PA_IR:  state_next = tms ? EX2_IR : PA_IR;
      EX2_IR: state_next = tms ? UPD_IR : SH_IR;
      UPD_IR: state_next = tms ? SEL_DR : RTI;
      default: state_next = TLR;
    endcase
  end

  // Pure decodes of the state register, so each strobe spans a whole TCK cycle.
  always_comb begin
    fsm_rst_n_sync = (state != TLR);
    fsm_dr_capture = (state == CAP_DR);
    fsm_dr_shift   = (state == SH_DR);
    fsm_dr_update  = (state == UPD_DR);
  end

  ycr_tapc_ir #(
    .YCR_IR_WIDTH  (YCR_IR_WIDTH),
    .YCR_IR_IDCODE (YCR_IR_IDCODE)
  ) i_ir (
    .clk      (clk),
    .rst      (rst),
    .tdi      (tdi),
    .tlr      (state == TLR),
    .capture  (state == CAP_IR),
    .shift    (state == SH_IR),
    .update   (state == UPD_IR),
    .ir_lsb   (ir_lsb),
    .ir_value (ir_value)
  );

  assign bypass_sel = (ir_value == YCR_IR_BYPASS) | ~dr_impl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bypass_q <= 1'b0;
    end else if (state == CAP_DR) begin
      bypass_q <= 1'b0;
    end else if (state == SH_DR) begin
      bypass_q <= tdi;
    end
  end

  // TDO holds outside the shift states so the last shifted bit stays on the pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo_en <= (state == SH_IR) | (state == SH_DR);
      if (state == SH_IR) begin
        tdo <= ir_lsb;
      end else if (state == SH_DR) begin
        tdo <= bypass_sel ? bypass_q : dr_tdo;
      end
    end
  end

endmodule

// File: tb/tb_ycr_tapc_fsm.sv
// Self-checking bench for ycr_tapc_fsm: hand-derived vector table, corner-case
// sequences and a randomized run against a name-based reference model.
module tb_ycr_tapc_fsm;

  localparam int W = 5;
  localparam logic [W-1:0] IDC = 5'h01;
  localparam logic [W-1:0] BYP = 5'h1F;

  logic         clk;
  logic         rst;
  logic         tms;
  logic         tdi;
  logic         dr_tdo;
  logic         dr_impl;
  logic         tdo;
  logic         tdo_en;
  logic         fsm_rst_n_sync;
  logic         fsm_dr_capture;
  logic         fsm_dr_shift;
  logic         fsm_dr_update;
  logic [W-1:0] ir_value;

  ycr_tapc_fsm dut (
    .clk            (clk),
    .rst            (rst),
    .tms            (tms),
    .tdi            (tdi),
    .dr_tdo         (dr_tdo),
    .dr_impl        (dr_impl),
    .tdo            (tdo),
    .tdo_en         (tdo_en),
    .fsm_rst_n_sync (fsm_rst_n_sync),
    .fsm_dr_capture (fsm_dr_capture),
    .fsm_dr_shift   (fsm_dr_shift),
    .fsm_dr_update  (fsm_dr_update),
    .ir_value       (ir_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    bit           rst;
    bit           tms;
    bit           tdi;
    bit           dr_tdo;
    bit           dr_impl;
    bit           tdo;
    bit           tdo_en;
    bit           rstn;
    bit           cap;
    bit           sh;
    bit           upd;
    logic [W-1:0] ir;
  } vec_t;

  vec_t tbl[$];

  // Reference model: states are named strings, IR shift stage is a bit queue.
  string        m_state;
  bit           m_irq[$];
  logic [W-1:0] m_ir;
  bit           m_byp;
  bit           m_tdo;
  bit           m_en;

  function automatic vec_t mk(bit r, bit t, bit di, bit dt, bit im,
                              bit o, bit e, bit rn, bit c, bit s, bit u, logic [W-1:0] ir);
    vec_t v;
    v.rst = r; v.tms = t; v.tdi = di; v.dr_tdo = dt; v.dr_impl = im;
    v.tdo = o; v.tdo_en = e; v.rstn = rn; v.cap = c; v.sh = s; v.upd = u; v.ir = ir;
    return v;
  endfunction

  function automatic string nextOf(string s, bit t);
    string side;
    string kind;
    if (s == "TLR") begin
      if (t) return "TLR";
      return "RTI";
    end
    if (s == "RTI" || s == "UPD_DR" || s == "UPD_IR") begin
      if (t) return "SEL_DR";
      return "RTI";
    end
    if (s == "SEL_DR") begin
      if (t) return "SEL_IR";
      return "CAP_DR";
    end
    if (s == "SEL_IR") begin
      if (t) return "TLR";
      return "CAP_IR";
    end
    side = s.substr(s.len() - 2, s.len() - 1);
    kind = s.substr(0, s.len() - 4);
    if (kind == "CAP" || kind == "SH") begin
      if (t) kind = "EX1";
      else   kind = "SH";
    end else if (kind == "EX1") begin
      if (t) kind = "UPD";
      else   kind = "PA";
    end else if (kind == "PA") begin
      if (t) kind = "EX2";
      else   kind = "PA";
    end else begin
      if (t) kind = "UPD";
      else   kind = "SH";
    end
    return {kind, "_", side};
  endfunction

  task automatic modelReset();
    m_state = "TLR";
    m_irq.delete();
    for (int i = 0; i < W; i++) m_irq.push_back(1'b0);
    m_ir  = IDC;
    m_byp = 1'b0;
    m_tdo = 1'b0;
    m_en  = 1'b0;
  endtask

  task automatic modelStep(bit t, bit di, bit dt, bit im);
    string s;
    s = m_state;
    if (s == "TLR") m_ir = IDC;
    if (s == "CAP_IR") begin
      m_irq.delete();
      m_irq.push_back(1'b1);
      for (int i = 1; i < W; i++) m_irq.push_back(1'b0);
    end
    if (s == "SH_IR") begin
      m_tdo = m_irq.pop_front();
      m_irq.push_back(di);
    end
    if (s == "UPD_IR") for (int i = 0; i < W; i++) m_ir[i] = m_irq[i];
    if (s == "CAP_DR") m_byp = 1'b0;
    if (s == "SH_DR") begin
      m_tdo = (m_ir == BYP || !im) ? m_byp : dt;
      m_byp = di;
    end
    m_en    = (s == "SH_IR") || (s == "SH_DR");
    m_state = nextOf(s, t);
  endtask

  task automatic checkOutput(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic checkModel(string tag);
    checkOutput({tag, " tdo"},       int'(tdo),            int'(m_tdo));
    checkOutput({tag, " tdo_en"},    int'(tdo_en),         int'(m_en));
    checkOutput({tag, " rst_n"},     int'(fsm_rst_n_sync), int'(m_state != "TLR"));
    checkOutput({tag, " capture"},   int'(fsm_dr_capture), int'(m_state == "CAP_DR"));
    checkOutput({tag, " shift"},     int'(fsm_dr_shift),   int'(m_state == "SH_DR"));
    checkOutput({tag, " update"},    int'(fsm_dr_update),  int'(m_state == "UPD_DR"));
    checkOutput({tag, " ir_value"},  int'(ir_value),       int'(m_ir));
  endtask

  // Inputs change on the falling edge; outputs are looked at 1 unit after the rising edge.
  task automatic applyStimulus(bit t, bit di, bit dt, bit im);
    @(negedge clk);
    rst = 1'b0; tms = t; tdi = di; dr_tdo = dt; dr_impl = im;
    @(posedge clk);
    modelStep(t, di, dt, im);
    #1;
  endtask

  task automatic step(string tag, bit t, bit di, bit dt, bit im);
    applyStimulus(t, di, dt, im);
    checkModel(tag);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; tms = 1'b1; tdi = 1'b0; dr_tdo = 1'b0; dr_impl = 1'b1;
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic loadIr(string tag, logic [W-1:0] val);
    step(tag, 0, 0, 0, 1);
    step(tag, 1, 0, 0, 1);
    step(tag, 1, 0, 0, 1);
    step(tag, 0, 0, 0, 1);
    step(tag, 0, 0, 0, 1);
    for (int i = 0; i < W; i++) step(tag, (i == W - 1), val[i], 0, 1);
    step(tag, 1, 0, 0, 1);
    step(tag, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1'b1; tms = 1'b1; tdi = 1'b0; dr_tdo = 1'b0; dr_impl = 1'b1;
    modelReset();

    //                 rst tms tdi dtd imp   tdo en rn cap sh upd ir
    tbl.push_back(mk(1, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0, IDC));
    tbl.push_back(mk(0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, IDC));
    tbl.push_back(mk(0, 1, 0, 0, 1,   0, 0, 1, 0, 0, 0, IDC));
    tbl.push_back(mk(0, 1, 0, 0, 1,   0, 0, 1, 0, 0, 0, IDC));
    tbl.push_back(mk(0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, IDC));
    tbl.push_back(mk(0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, IDC));
    tbl.push_back(mk(0, 0, 1, 0, 1,   1, 1, 1, 0, 0, 0, IDC));
    tbl.push_back(mk(0, 0, 1, 0, 1,   0, 1, 1, 0, 0, 0, IDC));
    tbl.push_back(mk(0, 0, 1, 0, 1,   0, 1, 1, 0, 0, 0, IDC));
    tbl.push_back(mk(0, 0, 1, 0, 1,   0, 1, 1, 0, 0, 0, IDC));
    tbl.push_back(mk(0, 1, 1, 0, 1,   0, 1, 1, 0, 0, 0, IDC));
    tbl.push_back(mk(0, 1, 0, 0, 1,   0, 0, 1, 0, 0, 0, IDC));
    tbl.push_back(mk(0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, BYP));
    tbl.push_back(mk(0, 1, 0, 0, 1,   0, 0, 1, 0, 0, 0, BYP));
    tbl.push_back(mk(0, 0, 0, 0, 1,   0, 0, 1, 1, 0, 0, BYP));
    tbl.push_back(mk(0, 0, 0, 0, 1,   0, 0, 1, 0, 1, 0, BYP));
    tbl.push_back(mk(0, 0, 1, 1, 1,   0, 1, 1, 0, 1, 0, BYP));
    tbl.push_back(mk(0, 0, 0, 0, 1,   1, 1, 1, 0, 1, 0, BYP));
    tbl.push_back(mk(0, 0, 1, 1, 1,   0, 1, 1, 0, 1, 0, BYP));
    tbl.push_back(mk(0, 1, 1, 0, 1,   1, 1, 1, 0, 0, 0, BYP));
    tbl.push_back(mk(0, 1, 0, 0, 1,   1, 0, 1, 0, 0, 1, BYP));
    tbl.push_back(mk(0, 0, 0, 0, 1,   1, 0, 1, 0, 0, 0, BYP));
    tbl.push_back(mk(1, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0, IDC));
    tbl.push_back(mk(0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, IDC));
    tbl.push_back(mk(0, 1, 0, 0, 1,   0, 0, 1, 0, 0, 0, IDC));
    tbl.push_back(mk(0, 0, 0, 0, 1,   0, 0, 1, 1, 0, 0, IDC));
    tbl.push_back(mk(0, 0, 0, 0, 1,   0, 0, 1, 0, 1, 0, IDC));
    tbl.push_back(mk(0, 0, 0, 1, 1,   1, 1, 1, 0, 1, 0, IDC));
    tbl.push_back(mk(0, 0, 0, 0, 1,   0, 1, 1, 0, 1, 0, IDC));
    tbl.push_back(mk(0, 0, 0, 1, 1,   1, 1, 1, 0, 1, 0, IDC));
    tbl.push_back(mk(0, 1, 0, 0, 1,   0, 1, 1, 0, 0, 0, IDC));
    tbl.push_back(mk(0, 0, 0, 0, 1,   0, 0, 1, 0, 0, 0, IDC));
    tbl.push_back(mk(0, 1, 0, 0, 1,   0, 0, 1, 0, 0, 0, IDC));
    tbl.push_back(mk(0, 0, 0, 0, 1,   0, 0, 1, 0, 1, 0, IDC));
    tbl.push_back(mk(0, 0, 1, 1, 0,   0, 1, 1, 0, 1, 0, IDC));
    tbl.push_back(mk(0, 0, 0, 1, 0,   1, 1, 1, 0, 1, 0, IDC));
    tbl.push_back(mk(0, 0, 1, 1, 0,   0, 1, 1, 0, 1, 0, IDC));
    tbl.push_back(mk(0, 1, 1, 0, 0,   1, 1, 1, 0, 0, 0, IDC));
    tbl.push_back(mk(0, 1, 0, 0, 1,   1, 0, 1, 0, 0, 1, IDC));
    tbl.push_back(mk(0, 1, 0, 0, 1,   1, 0, 1, 0, 0, 0, IDC));
    tbl.push_back(mk(0, 1, 0, 0, 1,   1, 0, 1, 0, 0, 0, IDC));
    tbl.push_back(mk(0, 1, 0, 0, 1,   1, 0, 0, 0, 0, 0, IDC));

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (tbl[i].rst) begin
        @(negedge clk);
        rst = 1'b1; tms = tbl[i].tms; tdi = tbl[i].tdi;
        dr_tdo = tbl[i].dr_tdo; dr_impl = tbl[i].dr_impl;
        modelReset();
        #2;
      end else begin
        applyStimulus(tbl[i].tms, tbl[i].tdi, tbl[i].dr_tdo, tbl[i].dr_impl);
      end
      checkOutput({tag, " tdo"},      int'(tdo),            int'(tbl[i].tdo));
      checkOutput({tag, " tdo_en"},   int'(tdo_en),         int'(tbl[i].tdo_en));
      checkOutput({tag, " rst_n"},    int'(fsm_rst_n_sync), int'(tbl[i].rstn));
      checkOutput({tag, " capture"},  int'(fsm_dr_capture), int'(tbl[i].cap));
      checkOutput({tag, " shift"},    int'(fsm_dr_shift),   int'(tbl[i].sh));
      checkOutput({tag, " update"},   int'(fsm_dr_update),  int'(tbl[i].upd));
      checkOutput({tag, " ir_value"}, int'(ir_value),       int'(tbl[i].ir));
    end

    // Five TMS=1 clocks from SH_DR land in TLR; IDCODE is reloaded while there.
    doReset();
    loadIr("tlr_seq", 5'h03);
    checkOutput("tlr_seq ir loaded", int'(ir_value), 32'h03);
    step("tlr_seq", 1, 0, 0, 1);
    step("tlr_seq", 0, 0, 0, 1);
    step("tlr_seq", 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step("tlr_seq", 1, 0, 0, 1);
    checkOutput("tlr_seq rst_n after 5", int'(fsm_rst_n_sync), 0);
    step("tlr_seq", 1, 0, 0, 1);
    checkOutput("tlr_seq ir idcode", int'(ir_value), int'(IDC));

    // Async reset in the middle of an IR shift: no update, outputs cleared at once.
    loadIr("rst_seq", BYP);
    checkOutput("rst_seq ir loaded", int'(ir_value), int'(BYP));
    step("rst_seq", 1, 0, 0, 1);
    step("rst_seq", 1, 0, 0, 1);
    step("rst_seq", 0, 0, 0, 1);
    step("rst_seq", 0, 0, 0, 1);
    step("rst_seq", 0, 0, 0, 1);
    checkOutput("rst_seq tdo before", int'(tdo), 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("rst_seq tdo",    int'(tdo),            0);
    checkOutput("rst_seq tdo_en", int'(tdo_en),         0);
    checkOutput("rst_seq rst_n",  int'(fsm_rst_n_sync), 0);
    checkOutput("rst_seq ir",     int'(ir_value),       int'(IDC));
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the reference model.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      bit t;
      if ($urandom_range(0, 399) == 0) doReset();
      t = ($urandom_range(0, 99) < 35);
      step("rand", t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
